// File: rtl/slope_sweep_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// slope_sweep_ctrl_pkg
// Shared constants and types for the slope-cell transfer-function sweeper:
//   - default widths, sweep length, settle/timeout budgets
//   - recording precision and the 30 % / 70 % slew thresholds
//   - the sweep FSM state encoding
//   - a small constant helper used to size counters
// -----------------------------------------------------------------------------
package slope_sweep_ctrl_pkg;

  localparam int SLOPE_FULL_SCALE  = 4096;   // top DAC code
  localparam int SLOPE_CODE_W      = 13;     // DAC code / abscissa width
  localparam int SLOPE_DATA_W      = 16;     // sample width, fraction of 2^16
  localparam int SLOPE_SETTLE_CYC  = 10;     // DAC settle time before strobing
  localparam int SLOPE_TIMEOUT_CYC = 1024;   // max wait for sample_valid
  localparam int SLOPE_ABS_PREC    = 66;     // ~1e-3 of full excursion
  localparam int SLOPE_LOW_THR     = 19661;  // 0.3 * 2^16
  localparam int SLOPE_HIGH_THR    = 45875;  // 0.7 * 2^16
  localparam int SLOPE_DEPTH       = 2048;   // table RAM entries

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DRIVE  = 3'd1,
    ST_STROBE = 3'd2,
    ST_WAIT   = 3'd3,
    ST_EVAL   = 3'd4,
    ST_NEXT   = 3'd5,
    ST_DONE   = 3'd6
  } sweep_state_e;

  // Larger of two elaboration-time integers (counter sizing).
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/slope_sweep_ctrl_if.sv
// -----------------------------------------------------------------------------
// slope_sweep_ctrl_if
// Bundles the two external buses of the sweeper:
//   measurement side : din_code (DAC code), get_val (sample strobe),
//                      sample_valid / sample (front-end response)
//   table side       : tab_we, tab_addr, tab_x, tab_y (point RAM write port)
// master = sweep controller, slave = DAC/front-end/table environment.
// -----------------------------------------------------------------------------
interface slope_sweep_ctrl_if #(
  parameter int CODE_W = 13,
  parameter int DATA_W = 16,
  parameter int ADDR_W = 11
);

  logic [CODE_W-1:0] din_code;
  logic              get_val;
  logic              sample_valid;
  logic [DATA_W-1:0] sample;
  logic              tab_we;
  logic [ADDR_W-1:0] tab_addr;
  logic [CODE_W-1:0] tab_x;
  logic [DATA_W-1:0] tab_y;

  modport master (
    output din_code,
    output get_val,
    input  sample_valid,
    input  sample,
    output tab_we,
    output tab_addr,
    output tab_x,
    output tab_y
  );

  modport slave (
    input  din_code,
    input  get_val,
    output sample_valid,
    output sample,
    input  tab_we,
    input  tab_addr,
    input  tab_x,
    input  tab_y
  );

endinterface

// File: rtl/slope_sweep_ctrl_bracket.sv
// -----------------------------------------------------------------------------
// slope_bracket
// Tracks the pair of recorded points that straddle one threshold T, for later
// linear interpolation of the crossing abscissa.
//   clk, rst_n  : clock, asynchronous active-low reset
//   clear       : re-seed (x0,y0) = (0,0), arm, drop found
//   rec_valid   : a recorded point (x, y) is presented this cycle
//   found       : (x0,y0) -> (x1,y1) is a valid rising bracket
//   x0/y0       : latest point below T
//   x1/y1       : first point at/above T after the latest below-T point
// A new below-T point re-arms the unit, so the latest rising crossing wins.
// -----------------------------------------------------------------------------
module slope_bracket #(
  parameter int T      = 19661,
  parameter int CODE_W = 13,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              rec_valid,
  input  logic [CODE_W-1:0] x,
  input  logic [DATA_W-1:0] y,
  output logic              found,
  output logic [CODE_W-1:0] x0,
  output logic [DATA_W-1:0] y0,
  output logic [CODE_W-1:0] x1,
  output logic [DATA_W-1:0] y1
);

  localparam logic [DATA_W-1:0] T_C = DATA_W'(T);

  logic              r_armed;
  logic              r_found;
  logic [CODE_W-1:0] r_x0;
  logic [DATA_W-1:0] r_y0;
  logic [CODE_W-1:0] r_x1;
  logic [DATA_W-1:0] r_y1;

  // Bracket state: seed on clear, then follow recorded points.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_armed <= 1'b0;
      r_found <= 1'b0;
      r_x0    <= '0;
      r_y0    <= '0;
      r_x1    <= '0;
      r_y1    <= '0;
    end else if (clear) begin
      r_armed <= 1'b1;
      r_found <= 1'b0;
      r_x0    <= '0;
      r_y0    <= '0;
      r_x1    <= '0;
      r_y1    <= '0;
    end else if (rec_valid) begin
      if (y < T_C) begin
        r_x0    <= x;
        r_y0    <= y;
        r_armed <= 1'b1;
      end else if (r_armed) begin
        // Only the first point above T after a below-T point closes it.
        r_x1    <= x;
        r_y1    <= y;
        r_found <= 1'b1;
        r_armed <= 1'b0;
      end else begin
        r_armed <= r_armed;
      end
    end else begin
      r_armed <= r_armed;
    end
  end

  assign found = r_found;
  assign x0    = r_x0;
  assign y0    = r_y0;
  assign x1    = r_x1;
  assign y1    = r_y1;

endmodule

// File: rtl/slope_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// slope_sweep_ctrl
// Sweeps the slope-cell DAC code from FULL_SCALE down to 0, strobes one sample
// per step, records points whose output moved by at least ABS_PREC into an
// external table RAM, and brackets the 30 % / 70 % threshold crossings.
//   clk, rst_n        : clock, asynchronous active-low reset
//   start             : begin a sweep (honoured in IDLE only)
//   bus (master)      : din_code/get_val/sample_valid/sample and table port
//   busy, done        : sweep in progress, one-cycle end-of-sweep pulse
//   err, ovf          : sticky timeout / table-overflow flags, cleared on start
//   nbval             : number of recorded points
//   lo_*, hi_*        : threshold brackets (found, x0, y0, x1, y1)
// All outputs are registered; state-decoded outputs are registered from the
// next state so they line up exactly with the state they belong to.
// -----------------------------------------------------------------------------
module slope_sweep_ctrl
  import slope_sweep_ctrl_pkg::*;
#(
  parameter int FULL_SCALE  = SLOPE_FULL_SCALE,
  parameter int CODE_W      = SLOPE_CODE_W,
  parameter int DATA_W      = SLOPE_DATA_W,
  parameter int SETTLE_CYC  = SLOPE_SETTLE_CYC,
  parameter int TIMEOUT_CYC = SLOPE_TIMEOUT_CYC,
  parameter int ABS_PREC    = SLOPE_ABS_PREC,
  parameter int LOW_THR     = SLOPE_LOW_THR,
  parameter int HIGH_THR    = SLOPE_HIGH_THR,
  parameter int DEPTH       = SLOPE_DEPTH,
  parameter int ADDR_W      = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  slope_sweep_ctrl_if.master bus,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              ovf,
  output logic [ADDR_W:0]   nbval,
  output logic              lo_found,
  output logic              hi_found,
  output logic [CODE_W-1:0] lo_x0,
  output logic [CODE_W-1:0] lo_x1,
  output logic [CODE_W-1:0] hi_x0,
  output logic [CODE_W-1:0] hi_x1,
  output logic [DATA_W-1:0] lo_y0,
  output logic [DATA_W-1:0] lo_y1,
  output logic [DATA_W-1:0] hi_y0,
  output logic [DATA_W-1:0] hi_y1
);

  localparam int CNT_W = $clog2(max_int(TIMEOUT_CYC, SETTLE_CYC) + 1);

  localparam logic [CODE_W-1:0] FS_C         = CODE_W'(FULL_SCALE);
  localparam logic [ADDR_W:0]   DEPTH_C      = (ADDR_W+1)'(DEPTH);
  localparam logic [DATA_W:0]   PREC_C       = (DATA_W+1)'(ABS_PREC);
  localparam logic [CNT_W-1:0]  SETTLE_LAST  = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0]  TIMEOUT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  sweep_state_e      r_state;
  sweep_state_e      w_next;
  logic [CNT_W-1:0]  r_cnt;
  logic [CODE_W-1:0] r_code;
  logic [DATA_W-1:0] r_last;
  logic [DATA_W-1:0] r_sample;
  logic              r_rec;
  logic [ADDR_W:0]   r_nbval;
  logic              r_err;
  logic              r_ovf;
  logic              r_busy;
  logic              r_done;
  logic              r_get_val;
  logic              r_tab_we;
  logic [ADDR_W-1:0] r_tab_addr;
  logic [CODE_W-1:0] r_tab_x;
  logic [DATA_W-1:0] r_tab_y;

  logic              w_busy_nx;
  logic              w_done_nx;
  logic              w_get_val_nx;
  logic              w_start_sweep;
  logic              w_accept;
  logic              w_timeout;
  logic              w_rec_new;
  logic              w_room;
  logic              w_eval_rec;
  logic [CODE_W-1:0] w_x;
  logic [DATA_W:0]   w_diff;
  logic [DATA_W:0]   w_abs;

  assign w_start_sweep = (r_state == ST_IDLE) && start;
  assign w_accept      = (r_state == ST_WAIT) && bus.sample_valid;
  assign w_timeout     = (r_state == ST_WAIT) && !bus.sample_valid &&
                         (r_cnt == TIMEOUT_LAST);
  assign w_x           = FS_C - r_code;
  assign w_room        = (r_nbval < DEPTH_C);

  // One extra bit keeps the signed difference of two unsigned samples exact.
  assign w_diff    = {1'b0, bus.sample} - {1'b0, r_last};
  assign w_abs     = w_diff[DATA_W] ? (-w_diff) : w_diff;
  assign w_rec_new = (w_abs >= PREC_C);

  // r_rec is latched on accept, so in EVAL it flags this step's point.
  assign w_eval_rec = (r_state == ST_EVAL) && r_rec;

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // FSM next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_next = ST_DRIVE;
        end else begin
          w_next = ST_IDLE;
        end
      end
      ST_DRIVE: begin
        if (r_cnt == SETTLE_LAST) begin
          w_next = ST_STROBE;
        end else begin
          w_next = ST_DRIVE;
        end
      end
      ST_STROBE: begin
        w_next = ST_WAIT;
      end
      ST_WAIT: begin
        if (bus.sample_valid) begin
          w_next = ST_EVAL;
        end else if (r_cnt == TIMEOUT_LAST) begin
          w_next = ST_DONE;
        end else begin
          w_next = ST_WAIT;
        end
      end
      ST_EVAL: begin
        w_next = ST_NEXT;
      end
      ST_NEXT: begin
        if (r_code == '0) begin
          w_next = ST_DONE;
        end else begin
          w_next = ST_DRIVE;
        end
      end
      ST_DONE: begin
        w_next = ST_IDLE;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  // FSM output decode, taken from the next state so the registered outputs
  // are high exactly while the FSM sits in the matching state.
  always_comb begin
    w_busy_nx    = 1'b0;
    w_done_nx    = 1'b0;
    w_get_val_nx = 1'b0;
    case (w_next)
      ST_IDLE: begin
        w_busy_nx = 1'b0;
      end
      ST_STROBE: begin
        w_busy_nx    = 1'b1;
        w_get_val_nx = 1'b1;
      end
      ST_DONE: begin
        w_busy_nx = 1'b1;
        w_done_nx = 1'b1;
      end
      default: begin
        w_busy_nx = 1'b1;
      end
    endcase
  end

  // Registered state-decoded outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_get_val <= 1'b0;
    end else begin
      r_busy    <= w_busy_nx;
      r_done    <= w_done_nx;
      r_get_val <= w_get_val_nx;
    end
  end

  // Per-state cycle counter: settle time in DRIVE, timeout in WAIT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (w_next != r_state) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // Sweep datapath: code, last recorded sample, point count, sticky flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_code   <= '0;
      r_last   <= '0;
      r_sample <= '0;
      r_rec    <= 1'b0;
      r_nbval  <= '0;
      r_err    <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_start_sweep) begin
        r_code  <= FS_C;
        r_last  <= '0;
        r_rec   <= 1'b0;
        r_nbval <= '0;
        r_err   <= 1'b0;
        r_ovf   <= 1'b0;
      end
      if (w_accept) begin
        r_sample <= bus.sample;
        r_rec    <= w_rec_new;
      end
      if (w_eval_rec) begin
        // A dropped point still becomes the new reference level.
        r_last <= r_sample;
        if (w_room) begin
          r_nbval <= r_nbval + (ADDR_W+1)'(1);
        end else begin
          r_ovf <= 1'b1;
        end
      end
      if (w_timeout) begin
        r_err <= 1'b1;
      end
      if ((r_state == ST_NEXT) && (r_code != '0)) begin
        r_code <= r_code - CODE_W'(1);
      end
    end
  end

  // Table write port: prepared on accept so the write lands in EVAL.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tab_we   <= 1'b0;
      r_tab_addr <= '0;
      r_tab_x    <= '0;
      r_tab_y    <= '0;
    end else if (w_accept && w_rec_new && w_room) begin
      r_tab_we   <= 1'b1;
      r_tab_addr <= r_nbval[ADDR_W-1:0];
      r_tab_x    <= w_x;
      r_tab_y    <= bus.sample;
    end else begin
      r_tab_we   <= 1'b0;
    end
  end

  slope_bracket #(
    .T      (LOW_THR),
    .CODE_W (CODE_W),
    .DATA_W (DATA_W)
  ) u_lo_bracket (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (w_start_sweep),
    .rec_valid (w_eval_rec),
    .x         (w_x),
    .y         (r_sample),
    .found     (lo_found),
    .x0        (lo_x0),
    .y0        (lo_y0),
    .x1        (lo_x1),
    .y1        (lo_y1)
  );

  slope_bracket #(
    .T      (HIGH_THR),
    .CODE_W (CODE_W),
    .DATA_W (DATA_W)
  ) u_hi_bracket (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (w_start_sweep),
    .rec_valid (w_eval_rec),
    .x         (w_x),
    .y         (r_sample),
    .found     (hi_found),
    .x0        (hi_x0),
    .y0        (hi_y0),
    .x1        (hi_x1),
    .y1        (hi_y1)
  );

  assign busy         = r_busy;
  assign done         = r_done;
  assign err          = r_err;
  assign ovf          = r_ovf;
  assign nbval        = r_nbval;
  assign bus.din_code = r_code;
  assign bus.get_val  = r_get_val;
  assign bus.tab_we   = r_tab_we;
  assign bus.tab_addr = r_tab_addr;
  assign bus.tab_x    = r_tab_x;
  assign bus.tab_y    = r_tab_y;

endmodule

// File: tb/tb_slope_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// tb_slope_sweep_ctrl
// Two sweepers share one responder: A (full table) and B (8-entry table).
// Sweep length and settle/timeout budgets are shortened to keep runs short;
// thresholds and precision keep their normal values.
// -----------------------------------------------------------------------------
module tb_slope_sweep_ctrl;
  import slope_sweep_ctrl_pkg::*;

  localparam int FS  = 1024;
  localparam int CW  = 13;
  localparam int DW  = 16;
  localparam int SET = 2;
  localparam int TO  = 64;
  localparam int DA  = 2048;
  localparam int DB  = 8;
  localparam int AWA = 11;
  localparam int AWB = 3;
  localparam int LAT = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start_a = 1'b0;
  logic start_b = 1'b0;

  always #5 clk = ~clk;

  logic busy_a, done_a, err_a, ovf_a, lo_f_a, hi_f_a;
  logic [AWA:0] nbval_a;
  logic [CW-1:0] lo_x0_a, lo_x1_a, hi_x0_a, hi_x1_a;
  logic [DW-1:0] lo_y0_a, lo_y1_a, hi_y0_a, hi_y1_a;
  logic busy_b, done_b, err_b, ovf_b, lo_f_b, hi_f_b;
  logic [AWB:0] nbval_b;
  logic [CW-1:0] lo_x0_b, lo_x1_b, hi_x0_b, hi_x1_b;
  logic [DW-1:0] lo_y0_b, lo_y1_b, hi_y0_b, hi_y1_b;

  slope_sweep_ctrl_if #(.CODE_W(CW), .DATA_W(DW), .ADDR_W(AWA)) bus_a ();
  slope_sweep_ctrl_if #(.CODE_W(CW), .DATA_W(DW), .ADDR_W(AWB)) bus_b ();

  slope_sweep_ctrl #(.FULL_SCALE(FS), .CODE_W(CW), .DATA_W(DW), .SETTLE_CYC(SET),
                     .TIMEOUT_CYC(TO), .DEPTH(DA)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(bus_a), .start(start_a),
    .busy(busy_a), .done(done_a), .err(err_a), .ovf(ovf_a), .nbval(nbval_a),
    .lo_found(lo_f_a), .hi_found(hi_f_a),
    .lo_x0(lo_x0_a), .lo_x1(lo_x1_a), .hi_x0(hi_x0_a), .hi_x1(hi_x1_a),
    .lo_y0(lo_y0_a), .lo_y1(lo_y1_a), .hi_y0(hi_y0_a), .hi_y1(hi_y1_a));

  slope_sweep_ctrl #(.FULL_SCALE(FS), .CODE_W(CW), .DATA_W(DW), .SETTLE_CYC(SET),
                     .TIMEOUT_CYC(TO), .DEPTH(DB)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(bus_b), .start(start_b),
    .busy(busy_b), .done(done_b), .err(err_b), .ovf(ovf_b), .nbval(nbval_b),
    .lo_found(lo_f_b), .hi_found(hi_f_b),
    .lo_x0(lo_x0_b), .lo_x1(lo_x1_b), .hi_x0(hi_x0_b), .hi_x1(hi_x1_b),
    .lo_y0(lo_y0_b), .lo_y1(lo_y1_b), .hi_y0(hi_y0_b), .hi_y1(hi_y1_b));

  typedef struct packed { int addr; int x; int y; } exp_t;
  exp_t q[$];

  int checks = 0;
  int errors = 0;
  int mode = 0;          // 0 linear 64x, 1 step at FS/2, 2 constant 0
  int silent_code = -1;  // strobe at this code gets no response
  int m_code, m_last, m_nbval;
  int gv_count, we_count, done_count, done_b_count, b_we_count, first_code;
  int cyc = 0, last_strobe_cyc = 0, done_cyc = 0;
  int rcnt = 0, resp_y = 0;
  bit b_check = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int resp(input int x);
    case (mode)
      0:       return (64 * x > 65535) ? 65535 : 64 * x;
      1:       return (x >= FS / 2) ? 65535 : 0;
      default: return 0;
    endcase
  endfunction

  // Responder, reference model and scoreboard, all sampled on the falling edge.
  always @(negedge clk) begin
    int x, y, d;
    bit sv;
    exp_t e;
    cyc++;
    if (!rst_n) begin
      rcnt = 0;
      bus_a.sample_valid = 1'b0;
      bus_b.sample_valid = 1'b0;
      bus_a.sample = '0;
      bus_b.sample = '0;
    end else begin
      sv = 1'b0;
      if (rcnt > 0) begin
        rcnt--;
        if (rcnt == 0) sv = 1'b1;
      end
      bus_a.sample_valid = sv;
      bus_b.sample_valid = sv;
      bus_a.sample = DW'(resp_y);
      bus_b.sample = DW'(resp_y);
      if (bus_a.get_val) begin
        gv_count++;
        if (gv_count == 1) first_code = m_code;
        chk("din_code", 32'(bus_a.din_code), m_code);
        last_strobe_cyc = cyc;
        if (m_code != silent_code) begin
          x = FS - m_code;
          y = resp(x);
          resp_y = y;
          rcnt = LAT;
          d = (y > m_last) ? y - m_last : m_last - y;
          if (d >= SLOPE_ABS_PREC) begin
            if (m_nbval < DA) begin
              q.push_back('{m_nbval, x, y});
              m_nbval++;
            end
            m_last = y;
          end
        end
        if (m_code > 0) m_code--;
      end
      if (bus_a.tab_we) begin
        we_count++;
        if (q.size() == 0) begin
          chk("sb_unexpected_write", 32'd1, 32'd0);
        end else begin
          e = q.pop_front();
          chk("tab_addr", 32'(bus_a.tab_addr), e.addr);
          chk("tab_x", 32'(bus_a.tab_x), e.x);
          chk("tab_y", 32'(bus_a.tab_y), e.y);
        end
      end
      if (b_check && bus_b.tab_we) begin
        chk("b_tab_addr", 32'(bus_b.tab_addr), b_we_count);
        chk("b_tab_x", 32'(bus_b.tab_x), 2 * (b_we_count + 1));
        chk("b_tab_y", 32'(bus_b.tab_y), 128 * (b_we_count + 1));
        b_we_count++;
      end
      if (done_a) begin
        done_count++;
        done_cyc = cyc;
      end
      if (done_b) done_b_count++;
    end
  end

  task automatic start_sweep(input int md, input bit with_b);
    mode = md;
    m_code = FS;
    m_last = 0;
    m_nbval = 0;
    q.delete();
    gv_count = 0;
    we_count = 0;
    done_count = 0;
    done_b_count = 0;
    b_we_count = 0;
    first_code = -1;
    start_a = 1'b1;
    start_b = with_b;
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic wait_done(input int limit);
    int n = 0;
    int base = done_count;
    while (done_count == base && n < limit) begin
      @(negedge clk);
      n++;
    end
    chk("done_within_budget", 32'(n < limit), 32'd1);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int n;
    // Reset values.
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy_a), 0);
    chk("rst_done", 32'(done_a), 0);
    chk("rst_err", 32'(err_a), 0);
    chk("rst_ovf", 32'(ovf_a), 0);
    chk("rst_nbval", 32'(nbval_a), 0);
    chk("rst_din_code", 32'(bus_a.din_code), 0);
    chk("rst_get_val", 32'(bus_a.get_val), 0);
    chk("rst_tab_we", 32'(bus_a.tab_we), 0);
    chk("rst_lo_found", 32'(lo_f_a), 0);
    chk("rst_hi_found", 32'(hi_f_a), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Linear ramp on A and B; a start pulse mid-sweep must be ignored.
    b_check = 1'b1;
    start_sweep(0, 1'b1);
    chk("busy_after_start", 32'(busy_a), 1);
    repeat (100) @(negedge clk);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    wait_done(12000);
    b_check = 1'b0;
    chk("lin_nbval", 32'(nbval_a), 512);
    chk("lin_writes", we_count, 512);
    chk("lin_sb_drained", q.size(), 0);
    chk("lin_strobes", gv_count, FS + 1);
    chk("lin_done_count", done_count, 1);
    chk("lin_busy", 32'(busy_a), 0);
    chk("lin_err", 32'(err_a), 0);
    chk("lin_ovf", 32'(ovf_a), 0);
    chk("lin_lo_found", 32'(lo_f_a), 1);
    chk("lin_lo_x0", 32'(lo_x0_a), 306);
    chk("lin_lo_y0", 32'(lo_y0_a), 19584);
    chk("lin_lo_x1", 32'(lo_x1_a), 308);
    chk("lin_lo_y1", 32'(lo_y1_a), 19712);
    chk("lin_hi_found", 32'(hi_f_a), 1);
    chk("lin_hi_x0", 32'(hi_x0_a), 716);
    chk("lin_hi_y0", 32'(hi_y0_a), 45824);
    chk("lin_hi_x1", 32'(hi_x1_a), 718);
    chk("lin_hi_y1", 32'(hi_y1_a), 45952);
    chk("b_nbval", 32'(nbval_b), DB);
    chk("b_writes", b_we_count, DB);
    chk("b_ovf", 32'(ovf_b), 1);
    chk("b_done_count", done_b_count, 1);
    chk("b_din_code_end", 32'(bus_b.din_code), 0);

    // Step response: single recorded point brackets both thresholds.
    start_sweep(1, 1'b0);
    wait_done(12000);
    chk("step_nbval", 32'(nbval_a), 1);
    chk("step_writes", we_count, 1);
    chk("step_lo", {lo_f_a, 3'd0, lo_x0_a, lo_y0_a}, {1'b1, 3'd0, 13'd0, 16'd0});
    chk("step_lo_pt1", {3'd0, lo_x1_a, lo_y1_a}, {3'd0, 13'd512, 16'd65535});
    chk("step_hi", {hi_f_a, 3'd0, hi_x0_a, hi_y0_a}, {1'b1, 3'd0, 13'd0, 16'd0});
    chk("step_hi_pt1", {3'd0, hi_x1_a, hi_y1_a}, {3'd0, 13'd512, 16'd65535});

    // Silent responder at code 1000: timeout after TO cycles of WAIT.
    silent_code = 1000;
    start_sweep(0, 1'b0);
    wait_done(2000);
    chk("to_err", 32'(err_a), 1);
    chk("to_done_count", done_count, 1);
    chk("to_busy", 32'(busy_a), 0);
    chk("to_strobes", gv_count, FS - 1000 + 1);
    chk("to_latency", done_cyc - last_strobe_cyc, TO + 1);
    silent_code = -1;

    // Next start clears err and completes normally.
    start_sweep(0, 1'b0);
    repeat (2) @(negedge clk);
    chk("restart_err_clear", 32'(err_a), 0);
    wait_done(12000);
    chk("restart_nbval", 32'(nbval_a), 512);
    chk("restart_err", 32'(err_a), 0);
    chk("restart_done_count", done_count, 1);

    // Asynchronous reset while waiting for a sample.
    start_sweep(0, 1'b0);
    n = 0;
    while (gv_count < 5 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("mid_reached", 32'(n < 3000), 1);
    @(negedge clk);
    chk("mid_busy_before", 32'(busy_a), 1);
    rst_n = 1'b0;
    #1;
    chk("mid_busy", 32'(busy_a), 0);
    chk("mid_din_code", 32'(bus_a.din_code), 0);
    chk("mid_nbval", 32'(nbval_a), 0);
    chk("mid_get_val", 32'(bus_a.get_val), 0);
    chk("mid_done", 32'(done_a), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("mid_no_done", done_count, 0);

    // Constant output after reset: nothing recorded, full sweep from FS.
    start_sweep(2, 1'b0);
    wait_done(12000);
    chk("const_first_code", first_code, FS);
    chk("const_nbval", 32'(nbval_a), 0);
    chk("const_writes", we_count, 0);
    chk("const_strobes", gv_count, FS + 1);
    chk("const_lo_found", 32'(lo_f_a), 0);
    chk("const_hi_found", 32'(hi_f_a), 0);
    chk("const_done_count", done_count, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/slope_sweep_ctrl.md
Name: slope_sweep_ctrl

Overview:
- Synthesizable sequencer for transfer-function characterization of the CMOS slope cell (inverter DUT driven by a DAC code, output sampled by a measurement front-end).
- Sweeps the input code from full scale down to 0 and handshakes one sample per step.
- Records only points where the output moved by at least a precision step, writing them to an external table RAM.
- Tracks the bracket points around the lower (30 %) and upper (70 %) slew thresholds for later interpolation and alpha computation.

Parameters:
- FULL_SCALE, 4096, top DAC code; sweep covers FULL_SCALE..0 (4097 steps).
- CODE_W, 13, DAC code / x width.
- DATA_W, 16, sample width; unsigned fraction of full excursion, value/2^16.
- SETTLE_CYC, 10, cycles din_code is held before strobing.
- TIMEOUT_CYC, 1024, max cycles waiting for sample_valid.
- ABS_PREC, 66, minimum |sample-last| to record a point (~1e-3).
- LOW_THR, 19661, lower slew threshold (0.3).
- HIGH_THR, 45875, upper slew threshold (0.7).
- DEPTH, 2048, table entries; ADDR_W = clog2(DEPTH).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin sweep (sampled in IDLE only)
- busy  out  1  sweep in progress
- done  out  1  one-cycle pulse at sweep end (normal or aborted)
- err  out  1  sticky timeout flag, cleared on start
- ovf  out  1  sticky table-overflow flag, cleared on start
- din_code  out  CODE_W  DAC input code
- get_val  out  1  one-cycle sample strobe
- sample_valid  in  1  sample present on sample
- sample  in  DATA_W  measured output
- tab_we  out  1  table write enable
- tab_addr  out  ADDR_W  table write address
- tab_x  out  CODE_W  x = FULL_SCALE - din_code
- tab_y  out  DATA_W  recorded sample
- nbval  out  ADDR_W+1  number of recorded points
- lo_found, hi_found  out  1 each  bracket valid
- lo_x0, lo_x1, hi_x0, hi_x1  out  CODE_W  bracket abscissas
- lo_y0, lo_y1, hi_y0, hi_y1  out  DATA_W  bracket ordinates

Behaviour:
- Reset values: all outputs 0; state IDLE; last = 0. Reset mid-sweep aborts immediately with get_val low and no done.
- FSM:
  - IDLE: on start, clear err, ovf, nbval, found flags and brackets; set last = 0, code = FULL_SCALE; go to DRIVE. start while busy is ignored.
  - DRIVE: din_code = code; hold SETTLE_CYC cycles; go to STROBE.
  - STROBE: get_val = 1 for exactly one cycle; go to WAIT.
  - WAIT: sample_valid is accepted from the cycle after STROBE onward, then go to EVAL. If TIMEOUT_CYC cycles elapse without it, set err and go to DONE.
  - EVAL (1 cycle): if |sample - last| >= ABS_PREC (unsigned compare on DATA_W+1 bits), the point is recorded:
    - If nbval < DEPTH: tab_we = 1 at tab_addr = nbval with (x, sample), then nbval++.
    - Else set ovf and drop the point.
    - last = sample in both cases.
    - Bracket units update only on recorded points, including dropped ones.
    - Then go to NEXT.
  - NEXT: if code == 0, go to DONE; else code--, go to DRIVE.
  - DONE: done = 1 for one cycle; go to IDLE. din_code holds its last value.
- busy = 1 in every state except IDLE.
- Bracket per threshold T, seeded at start with (x0, y0) = (0, 0) and armed = 1:
  - Recorded y < T: x0/y0 = point, armed = 1.
  - Recorded y >= T while armed: x1/y1 = point, found = 1, armed = 0.
  - Latest rising crossing wins.
- Both brackets update in the same EVAL cycle; no priority interaction.
- Latency per step: SETTLE_CYC + 1 + (responder latency, ≥1) + 1 + 1 cycles.

Decomposition:
- slope_pkg: CODE_W/DATA_W defaults, threshold and precision constants, state enum.
- Sub-module slope_bracket (params T, widths), instantiated twice (lo, hi). Inputs: clear, rec_valid, x, y. Outputs: found, x0, y0, x1, y1.

Test Plan:
- Linear responder y = min(16·x, 65535), latency 3 -> nbval = 819, tab[k] = (5(k+1), 80(k+1)).
  - lo bracket = (1225, 19600) -> (1230, 19680).
  - hi bracket = (2865, 45840) -> (2870, 45920).
  - Exactly one done; err = ovf = 0.
- Step responder y = 65535 for x >= 2048, else 0 -> nbval = 1, tab[0] = (2048, 65535).
  - Both brackets = (0, 0) -> (2048, 65535); both found.
- Constant 0 -> nbval = 0, tab_we never asserted, found = 0, 4097 get_val pulses before done.
- Linear responder with DEPTH = 8 -> exactly 8 writes (addresses 0..7), nbval = 8, ovf = 1; sweep still completes 4097 steps.
- Responder silent at code 4000 -> err = 1 after TIMEOUT_CYC cycles, done pulse, busy = 0.
  - Next start clears err and the sweep completes normally.
- start pulsed while busy is ignored.
- rst_n asserted in WAIT -> all outputs 0 asynchronously, no done.
  - Fresh start after reset begins at code 4096.
